// File: rtl/tag_pkg.sv
// Shared types and width helpers for the two-bank tag store controller.
package tag_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONF  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic int adr_w(input int satir);
    return $clog2(satir);
  endfunction

  function automatic int bank_w(input int satir);
    return $clog2(satir) - 1;
  endfunction

endpackage

// File: rtl/tag_banka_secici.sv
// Maps the two read-port line addresses onto the even/odd tag banks.
module tag_banka_secici
  import tag_pkg::*;
#(
  parameter int SATIR = 512,
  localparam int ADR_W = adr_w(SATIR),
  localparam int BANK_W = bank_w(SATIR)
) (
  input  logic [ADR_W-1:0]  radr0,
  input  logic [ADR_W-1:0]  radr1,
  output logic [BANK_W-1:0] adr_even,
  output logic [BANK_W-1:0] adr_odd,
  output logic              conflict,
  output logic              sel0,
  output logic              sel1
);

  always_comb begin
    sel0     = radr0[0];
    sel1     = radr1[0];
    conflict = (radr0[0] == radr1[0]) && (radr0 != radr1);
    adr_even = '0;
    adr_odd  = '0;
    // Port 1 is assigned first so port 0 owns a bank both ports want.
    if (!radr1[0]) adr_even = radr1[ADR_W-1:1];
    if (radr1[0])  adr_odd  = radr1[ADR_W-1:1];
    if (!radr0[0]) adr_even = radr0[ADR_W-1:1];
    if (radr0[0])  adr_odd  = radr0[ADR_W-1:1];
  end

endmodule

// File: rtl/tag_bellek_denetleyici.sv
// Two-bank tag store controller: dual read ports with conflict serialisation,
// valid-bit ownership, per-port hit compare and a multi-cycle flush sweep.
module tag_bellek_denetleyici
  import tag_pkg::*;
#(
  parameter int SATIR = 512,
  parameter int TAG_W = 8,
  localparam int ADR_W = adr_w(SATIR),
  localparam int BANK_W = bank_w(SATIR)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_valid_i,
  output logic              rd_ready_o,
  input  logic [ADR_W-1:0]  radr0_i,
  input  logic [ADR_W-1:0]  radr1_i,
  input  logic [TAG_W-1:0]  cmp0_i,
  input  logic [TAG_W-1:0]  cmp1_i,
  output logic              rd_rvalid_o,
  output logic [TAG_W:0]    data0_o,
  output logic [TAG_W:0]    data1_o,
  output logic              hit0_o,
  output logic              hit1_o,
  input  logic              wen_i,
  input  logic [ADR_W-1:0]  wadr_i,
  input  logic [TAG_W-1:0]  wtag_i,
  input  logic              inv_i,
  input  logic [ADR_W-1:0]  inv_adr_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              we0_o,
  output logic              we1_o,
  output logic [BANK_W-1:0] adr0_o,
  output logic [BANK_W-1:0] adr1_o,
  output logic [TAG_W-1:0]  wdata0_o,
  output logic [TAG_W-1:0]  wdata1_o,
  input  logic [TAG_W-1:0]  rdata0_i,
  input  logic [TAG_W-1:0]  rdata1_i
);

  state_t state_q, state_d;
  logic [SATIR-1:0]  valid_q;
  logic [BANK_W-1:0] cnt_q;
  logic              rv_q, held_q;
  logic              sel0_q, sel1_q, v0_q, v1_q;
  logic [TAG_W-1:0]  cmp0_q, cmp1_q;
  logic [ADR_W-1:0]  radr1_q;
  logic [TAG_W:0]    hold0_q;

  logic [BANK_W-1:0] adr_even, adr_odd;
  logic              conflict, sel0, sel1;
  logic              accept, wr, clr_all;
  logic [TAG_W:0]    word0, word1;

  tag_banka_secici #(.SATIR(SATIR)) u_secici (
    .radr0    (radr0_i),
    .radr1    (radr1_i),
    .adr_even (adr_even),
    .adr_odd  (adr_odd),
    .conflict (conflict),
    .sel0     (sel0),
    .sel1     (sel1)
  );

  always_comb begin
    state_d    = state_q;
    rd_ready_o = 1'b0;
    we0_o      = 1'b0;
    we1_o      = 1'b0;
    adr0_o     = '0;
    adr1_o     = '0;
    wdata0_o   = '0;
    wdata1_o   = '0;
    accept     = 1'b0;
    wr         = 1'b0;
    clr_all    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Requests are not decoded while reset is held.
        if (rst_ni) begin
          if (flush_i) begin
            state_d = FLUSH;
            clr_all = 1'b1;
          end else if (wen_i) begin
            wr = 1'b1;
            if (wadr_i[0]) begin
              we1_o    = 1'b1;
              adr1_o   = wadr_i[ADR_W-1:1];
              wdata1_o = wtag_i;
            end else begin
              we0_o    = 1'b1;
              adr0_o   = wadr_i[ADR_W-1:1];
              wdata0_o = wtag_i;
            end
          end else begin
            rd_ready_o = 1'b1;
            if (rd_valid_i) begin
              accept = 1'b1;
              adr0_o = adr_even;
              adr1_o = adr_odd;
              if (conflict) state_d = CONF;
            end
          end
        end
      end
      CONF: begin
        if (radr1_q[0]) adr1_o = radr1_q[ADR_W-1:1];
        else            adr0_o = radr1_q[ADR_W-1:1];
        state_d = IDLE;
      end
      FLUSH: begin
        we0_o  = 1'b1;
        we1_o  = 1'b1;
        adr0_o = cnt_q;
        adr1_o = cnt_q;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      held_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == FLUSH) ? cnt_q + 1'b1 : '0;
      rv_q    <= (accept && !conflict) || (state_q == CONF);
      held_q  <= (state_q == CONF);
      if (clr_all) begin
        valid_q <= '0;
      end else if (state_q != FLUSH) begin
        // The write is applied last so it wins over a same-line invalidate.
        if (inv_i) valid_q[inv_adr_i] <= 1'b0;
        if (wr)    valid_q[wadr_i]    <= 1'b1;
      end
    end
  end

  // Issue stage: capture per-port context; SRAM data arrives next cycle.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      sel0_q  <= sel0;
      sel1_q  <= sel1;
      v0_q    <= valid_q[radr0_i];
      v1_q    <= valid_q[radr1_i];
      cmp0_q  <= cmp0_i;
      cmp1_q  <= cmp1_i;
      radr1_q <= radr1_i;
    end
    if (state_q == CONF) begin
      hold0_q <= word0;
      sel1_q  <= radr1_q[0];
      v1_q    <= valid_q[radr1_q];
    end
  end

  // Result stage.
  assign word0       = {v0_q, sel0_q ? rdata1_i : rdata0_i};
  assign word1       = {v1_q, sel1_q ? rdata1_i : rdata0_i};
  assign data0_o     = !rv_q ? '0 : (held_q ? hold0_q : word0);
  assign data1_o     = rv_q ? word1 : '0;
  assign hit0_o      = data0_o[TAG_W] && (data0_o[TAG_W-1:0] == cmp0_q);
  assign hit1_o      = data1_o[TAG_W] && (data1_o[TAG_W-1:0] == cmp1_q);
  assign rd_rvalid_o = rv_q;
  assign busy_o      = (state_q == FLUSH);

endmodule

// File: tb/tb_tag_bellek_denetleyici.sv
// Directed bench with a response scoreboard and bank SRAM models for the tag store controller.
module tb_tag_bellek_denetleyici;

  localparam int SATIR = 512;
  localparam int TAG_W = 8;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       rd_valid_i, rd_ready_o, rd_rvalid_o;
  logic [8:0] radr0_i, radr1_i, wadr_i, inv_adr_i;
  logic [7:0] cmp0_i, cmp1_i, wtag_i;
  logic [8:0] data0_o, data1_o;
  logic       hit0_o, hit1_o, wen_i, inv_i, flush_i, busy_o;
  logic       we0_o, we1_o;
  logic [7:0] adr0_o, adr1_o, wdata0_o, wdata1_o;
  logic [7:0] rdata0_i, rdata1_i;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [8:0] d0;
    logic [8:0] d1;
    logic       h0;
    logic       h1;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  always #5 clk = ~clk;

  tag_bellek_denetleyici #(.SATIR(SATIR), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o),
    .radr0_i(radr0_i), .radr1_i(radr1_i), .cmp0_i(cmp0_i), .cmp1_i(cmp1_i),
    .rd_rvalid_o(rd_rvalid_o), .data0_o(data0_o), .data1_o(data1_o),
    .hit0_o(hit0_o), .hit1_o(hit1_o),
    .wen_i(wen_i), .wadr_i(wadr_i), .wtag_i(wtag_i),
    .inv_i(inv_i), .inv_adr_i(inv_adr_i),
    .flush_i(flush_i), .busy_o(busy_o),
    .we0_o(we0_o), .we1_o(we1_o), .adr0_o(adr0_o), .adr1_o(adr1_o),
    .wdata0_o(wdata0_o), .wdata1_o(wdata1_o),
    .rdata0_i(rdata0_i), .rdata1_i(rdata1_i)
  );

  // Synchronous single-port bank models, one-cycle read latency.
  always @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
      rdata0_i <= '0;
      rdata1_i <= '0;
    end else begin
      if (we0_o) mem0[adr0_o] <= wdata0_o;
      if (we1_o) mem1[adr1_o] <= wdata1_o;
      rdata0_i <= mem0[adr0_o];
      rdata1_i <= mem1[adr1_o];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rd_rvalid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data0", data0_o, e.d0);
        chk("sb_data1", data1_o, e.d1);
        chk("sb_hit0", hit0_o, e.h0);
        chk("sb_hit1", hit1_o, e.h1);
      end
    end
  end

  task automatic wr(input logic [8:0] a, input logic [7:0] t);
    wen_i = 1'b1; wadr_i = a; wtag_i = t;
    #1;
    chk("wr_ready_low", rd_ready_o, 1'b0);
    chk("wr_we", {we1_o, we0_o}, a[0] ? 2'b10 : 2'b01);
    chk("wr_adr", a[0] ? adr1_o : adr0_o, a[8:1]);
    chk("wr_wdata", a[0] ? wdata1_o : wdata0_o, t);
    step();
    wen_i = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a0, input logic [8:0] a1,
                    input logic [7:0] c0, input logic [7:0] c1,
                    input logic [8:0] e0, input logic [8:0] e1,
                    input bit conf, input int xa0 = -1, input int xa1 = -1);
    exp_t e;
    rd_valid_i = 1'b1; radr0_i = a0; radr1_i = a1; cmp0_i = c0; cmp1_i = c1;
    e.d0 = e0; e.d1 = e1;
    e.h0 = e0[8] && (e0[7:0] == c0);
    e.h1 = e1[8] && (e1[7:0] == c1);
    sb.push_back(e);
    #1;
    chk("rd_accept", rd_ready_o, 1'b1);
    if (xa0 >= 0) chk("rd_adr0", adr0_o, xa0);
    if (xa1 >= 0) chk("rd_adr1", adr1_o, xa1);
    step();
    rd_valid_i = 1'b0; radr0_i = '0; radr1_i = '0; cmp0_i = '0; cmp1_i = '0;
    if (conf) begin
      #1;
      chk("conf_ready", rd_ready_o, 1'b0);
      chk("conf_rvalid_early", rd_rvalid_o, 1'b0);
      chk("conf_adr", a1[0] ? adr1_o : adr0_o, a1[8:1]);
      step();
    end
    #1;
    chk("rvalid_latency", rd_rvalid_o, 1'b1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int nz;
    rd_valid_i = 0; radr0_i = '0; radr1_i = '0; cmp0_i = '0; cmp1_i = '0;
    wen_i = 0; wadr_i = '0; wtag_i = '0; inv_i = 0; inv_adr_i = '0; flush_i = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", rd_ready_o, 1'b0);
    chk("rst_rvalid", rd_rvalid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_we", {we1_o, we0_o}, 2'b00);
    chk("rst_adr", {adr1_o, adr0_o}, 16'h0);
    chk("rst_wdata", {wdata1_o, wdata0_o}, 16'h0);
    chk("rst_data", {data1_o, data0_o}, 18'h0);
    chk("rst_hit", {hit1_o, hit0_o}, 2'b00);
    rst_ni = 1'b1;
    step();
    chk("idle_ready", rd_ready_o, 1'b1);

    rd(9'd5, 9'd5, 8'h00, 8'h00, 9'h000, 9'h000, 0);

    wr(9'd4, 8'hA5);
    wr(9'd5, 8'h3C);
    rd(9'd5, 9'd4, 8'h3C, 8'hA5, 9'h13C, 9'h1A5, 0, 2, 2);
    rd(9'd4, 9'd5, 8'hA5, 8'h00, 9'h1A5, 9'h13C, 0);

    wr(9'd511, 8'h11);
    wr(9'd0, 8'h22);
    rd(9'd0, 9'd511, 8'h22, 8'h11, 9'h122, 9'h111, 0, 0, 255);

    wr(9'd6, 8'h66);
    wr(9'd2, 8'h2B);
    rd(9'd6, 9'd2, 8'h66, 8'h2B, 9'h166, 9'h12B, 1, 3, 0);

    inv_i = 1'b1; inv_adr_i = 9'd4;
    step();
    inv_i = 1'b0;
    rd(9'd4, 9'd4, 8'hA5, 8'hA5, 9'h0A5, 9'h0A5, 0);
    inv_i = 1'b1; inv_adr_i = 9'd5;
    rd(9'd5, 9'd4, 8'h3C, 8'hA5, 9'h13C, 9'h0A5, 0);
    inv_i = 1'b0;
    rd(9'd5, 9'd5, 8'h3C, 8'h3C, 9'h03C, 9'h03C, 0);

    wen_i = 1'b1; wadr_i = 9'd7; wtag_i = 8'h5A; inv_i = 1'b1; inv_adr_i = 9'd7;
    step();
    wen_i = 1'b0; inv_i = 1'b0;
    rd(9'd7, 9'd7, 8'h5A, 8'h5A, 9'h15A, 9'h15A, 0);

    rd_valid_i = 1'b1; radr0_i = 9'd6; radr1_i = 9'd2;
    step();
    rd_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("rst_conf_ready", rd_ready_o, 1'b0);
    step();
    chk("rst_conf_dropped", rd_rvalid_o, 1'b0);
    rst_ni = 1'b1;
    step();
    chk("rst_conf_idle", rd_ready_o, 1'b1);

    wr(9'd4, 8'hA5);
    wr(9'd7, 8'h5A);
    wr(9'd510, 8'hF0);
    flush_i = 1'b1;
    #1;
    chk("flush_entry_ready", rd_ready_o, 1'b0);
    step();
    flush_i = 1'b0;
    n = 0;
    for (int i = 0; i < 300 && busy_o; i++) begin
      if (i == 5) begin
        chk("flush_ready", rd_ready_o, 1'b0);
        chk("flush_we", {we1_o, we0_o}, 2'b11);
        chk("flush_adr", {adr1_o, adr0_o}, {8'd5, 8'd5});
        chk("flush_wdata", {wdata1_o, wdata0_o}, 16'h0);
      end
      wen_i = (i == 10);
      wadr_i = 9'd9;
      wtag_i = 8'h77;
      n++;
      step();
    end
    wen_i = 1'b0;
    chk("flush_busy_cycles", n, 256);
    nz = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem0[i] != 8'h00) nz++;
      if (mem1[i] != 8'h00) nz++;
    end
    chk("flush_zeroed", nz, 0);
    rd(9'd9, 9'd8, 8'h77, 8'h00, 9'h000, 9'h000, 0);
    rd(9'd7, 9'd4, 8'h00, 8'h00, 9'h000, 9'h000, 0);

    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    repeat (20) step();
    chk("midflush_busy", busy_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("midflush_rst_busy", busy_o, 1'b0);
    chk("midflush_rst_we", {we1_o, we0_o}, 2'b00);
    step();
    rst_ni = 1'b1;
    step();
    chk("after_rst_ready", rd_ready_o, 1'b1);
    chk("after_rst_busy", busy_o, 1'b0);

    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
